// File: rtl/iter_mul_if.sv
// iter_mul_if -- request/response bundle for the iterative multiplier.
//   master : drives start, op, a, b; observes busy, done, result_lo,
//            result_hi, nz
//   slave  : the multiplier side of the same signals
interface iter_mul_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [1:0]       nz;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, nz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, nz
    );
endinterface

// File: rtl/iter_mul.sv
// iter_mul -- iterative shift-add multiplier, BPC multiplier bits per cycle.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : iter_mul_if slave modport
//            start/op/a/b in; busy/done/result_lo/result_hi/nz out
//   op     : 00 MUL (low half only), 01 UMULL, 10 SMULL, 11 treated as MUL
// Operation: capture (IDLE/DONE) -> WIDTH/BPC RUN cycles -> SIGN -> DONE.
module iter_mul #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic      clk,
    input  logic      reset,
    iter_mul_if.slave bus
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t             state;
    state_t             state_nx;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   res_hi;
    logic [1:0]         nz_q;

    logic               smull;
    logic               is_mul;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_final;
    logic [WIDTH-1:0]   fin_lo;
    logic [WIDTH-1:0]   fin_hi;

    // Operand magnitudes for SMULL; -2^(WIDTH-1) maps to 2^(WIDTH-1), which
    // is representable as an unsigned WIDTH-bit value.
    always_comb begin
        smull = (bus.op == 2'b10);
        a_mag = (smull && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (smull && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // mcand is pre-shifted to the weight of mplier[0], so each RUN cycle only
    // needs the BPC-bit digit product.
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    always_comb begin
        is_mul    = (op_q[1] == op_q[0]);
        acc_final = neg ? -acc : acc;
        fin_lo    = acc_final[WIDTH-1:0];
        fin_hi    = is_mul ? '0 : acc_final[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = bus.start ? RUN : IDLE;
            RUN:        if (count == CW'(1)) state_nx = SIGN;
            SIGN:       state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            op_q   <= '0;
            res_lo <= '0;
            res_hi <= '0;
            nz_q   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        mcand  <= (2*WIDTH)'(a_mag);
                        mplier <= b_mag;
                        neg    <= smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        count  <= CW'(N);
                        acc    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BPC;
                    mplier <= mplier >> BPC;
                    count  <= count - CW'(1);
                end
                SIGN: begin
                    // Sign fix-up and result registration share this edge so
                    // the outputs change exactly when DONE is entered.
                    acc    <= acc_final;
                    res_lo <= fin_lo;
                    res_hi <= fin_hi;
                    nz_q   <= is_mul ? {fin_lo[WIDTH-1], fin_lo == '0}
                                     : {fin_hi[WIDTH-1], acc_final == '0};
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == RUN) || (state == SIGN);
    assign bus.done      = (state == DONE);
    assign bus.result_lo = res_lo;
    assign bus.result_hi = res_hi;
    assign bus.nz        = nz_q;
endmodule

// File: tb/tb_iter_mul.sv
// tb_iter_mul -- checks iter_mul at WIDTH=32 with BPC=1 and BPC=4 side by
// side against an arithmetic reference model, plus directed literal cases.
module tb_iter_mul;
    logic        clk     = 1'b0;
    logic        reset_s = 1'b1;
    logic        start_s = 1'b0;
    logic [1:0]  op_s    = 2'b00;
    logic [31:0] a_s     = '0;
    logic [31:0] b_s     = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iter_mul_if #(.WIDTH(32)) bus1 ();
    iter_mul_if #(.WIDTH(32)) bus4 ();

    assign bus1.start = start_s;
    assign bus1.op    = op_s;
    assign bus1.a     = a_s;
    assign bus1.b     = b_s;
    assign bus4.start = start_s;
    assign bus4.op    = op_s;
    assign bus4.a     = a_s;
    assign bus4.b     = b_s;

    iter_mul #(.WIDTH(32), .BPC(1)) u1 (.clk(clk), .reset(reset_s), .bus(bus1));
    iter_mul #(.WIDTH(32), .BPC(4)) u4 (.clk(clk), .reset(reset_s), .bus(bus4));

    logic        dn_o [2];
    logic        bs_o [2];
    logic [31:0] lo_o [2];
    logic [31:0] hi_o [2];
    logic [1:0]  nz_o [2];

    assign dn_o[0] = bus1.done;
    assign bs_o[0] = bus1.busy;
    assign lo_o[0] = bus1.result_lo;
    assign hi_o[0] = bus1.result_hi;
    assign nz_o[0] = bus1.nz;
    assign dn_o[1] = bus4.done;
    assign bs_o[1] = bus4.busy;
    assign lo_o[1] = bus4.result_lo;
    assign hi_o[1] = bus4.result_hi;
    assign nz_o[1] = bus4.nz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Product as plain 64-bit arithmetic; returns {nz, hi, lo}.
    function automatic logic [65:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [1:0]  nz;
        case (op)
            2'b01:   p = {32'b0, a} * {32'b0, b};
            2'b10:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        lo = p[31:0];
        if (op == 2'b01 || op == 2'b10) begin
            hi = p[63:32];
            nz = {hi[31], p == 64'd0};
        end else begin
            hi = '0;
            nz = {lo[31], lo == 32'd0};
        end
        return {nz, hi, lo};
    endfunction

    function automatic int nn(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    // Reference model: an accepted start schedules the result N+1 edges later.
    int          rem   [2] = '{0, 0};
    logic [65:0] pend  [2] = '{66'd0, 66'd0};
    logic [65:0] outv  [2] = '{66'd0, 66'd0};
    logic        mdone [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge reset_s) begin
        if (!reset_s) begin
            for (int d = 0; d < 2; d++) begin
                rem[d]   <= 0;
                outv[d]  <= '0;
                mdone[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (rem[d] == 0) begin
                    mdone[d] <= 1'b0;
                    if (start_s) begin
                        rem[d]  <= nn(d) + 1;
                        pend[d] <= ref_mul(op_s, a_s, b_s);
                    end
                end else begin
                    rem[d] <= rem[d] - 1;
                    if (rem[d] == 1) begin
                        mdone[d] <= 1'b1;
                        outv[d]  <= pend[d];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("u%0d.done", d), 64'(dn_o[d]), 64'(mdone[d]));
            check($sformatf("u%0d.busy", d), 64'(bs_o[d]), 64'(rem[d] > 0));
            check($sformatf("u%0d.lo", d),   64'(lo_o[d]), 64'(outv[d][31:0]));
            check($sformatf("u%0d.hi", d),   64'(hi_o[d]), 64'(outv[d][63:32]));
            check($sformatf("u%0d.nz", d),   64'(nz_o[d]), 64'(outv[d][65:64]));
        end
    end

    // Caller sits at a negedge; start is raised now and dropped one cycle
    // later, after which a/b/op are scrambled. k counts negedges after start.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int extra_k, output int k1, output int k4,
                          output int busy1, output logic [31:0] lo_k1);
        int k;
        k     = 0;
        k1    = -1;
        k4    = -1;
        busy1 = 0;
        lo_k1 = '0;
        start_s = 1'b1;
        op_s    = op;
        a_s     = a;
        b_s     = b;
        while (k1 < 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) lo_k1 = lo_o[0];
            if (bs_o[0]) busy1++;
            if (dn_o[1] && k4 < 0) k4 = k;
            if (dn_o[0]) k1 = k;
            start_s = (k == extra_k);
            op_s    = 2'($urandom_range(0, 3));
            a_s     = $urandom;
            b_s     = $urandom;
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int          k1;
        int          k4;
        int          bz;
        logic [31:0] lk;
        logic [1:0]  rop;

        #1 reset_s = 1'b0;
        #1;
        check("rst.busy", 64'(bus1.busy), 64'd0);
        check("rst.done", 64'(bus1.done), 64'd0);
        check("rst.lo",   64'(bus1.result_lo), 64'd0);
        check("rst.hi",   64'(bus1.result_hi), 64'd0);
        check("rst.nz",   64'(bus1.nz), 64'd0);
        repeat (2) @(negedge clk);
        #2 reset_s = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'd7, 32'd6, 0, k1, k4, bz, lk);
        check("mul7x6.lat",  64'(k1), 64'd34);
        check("mul7x6.busy", 64'(bz), 64'd33);
        check("mul7x6.lat4", 64'(k4), 64'd10);
        check("mul7x6.lo",   64'(lo_o[0]), 64'd42);
        check("mul7x6.hi",   64'(hi_o[0]), 64'd0);
        check("mul7x6.nz",   64'(nz_o[0]), 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, k1, k4, bz, lk);
        check("b2b.held_lo", 64'(lk), 64'd42);
        check("umull.lat",   64'(k1), 64'd34);
        check("umull.hi",    64'(hi_o[0]), 64'hFFFF_FFFE);
        check("umull.lo",    64'(lo_o[0]), 64'h1);
        check("umull.nz",    64'(nz_o[0]), 64'b10);

        run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 0, k1, k4, bz, lk);
        check("smull_min.hi", 64'(hi_o[0]), 64'h4000_0000);
        check("smull_min.lo", 64'(lo_o[0]), 64'h0);
        check("smull_min.nz", 64'(nz_o[0]), 64'b00);

        @(negedge clk);
        run_op(2'b10, 32'hFFFF_FFFF, 32'h1, 0, k1, k4, bz, lk);
        check("smull_m1.hi", 64'(hi_o[0]), 64'hFFFF_FFFF);
        check("smull_m1.lo", 64'(lo_o[0]), 64'hFFFF_FFFF);
        check("smull_m1.nz", 64'(nz_o[0]), 64'b10);

        run_op(2'b00, 32'h0, 32'h1234, 0, k1, k4, bz, lk);
        check("mul0.lo", 64'(lo_o[0]), 64'h0);
        check("mul0.nz", 64'(nz_o[0]), 64'b01);

        run_op(2'b11, 32'h1_0000, 32'h1_0000, 0, k1, k4, bz, lk);
        check("op11.hi", 64'(hi_o[0]), 64'h0);
        check("op11.lo", 64'(lo_o[0]), 64'h0);
        check("op11.nz", 64'(nz_o[0]), 64'b01);

        @(negedge clk);
        run_op(2'b00, 32'd9, 32'd9, 4, k1, k4, bz, lk);
        check("ignore.lat",  64'(k1), 64'd34);
        check("ignore.lat4", 64'(k4), 64'd10);
        check("ignore.lo",   64'(lo_o[0]), 64'd81);

        @(negedge clk);
        start_s = 1'b1;
        op_s    = 2'b00;
        a_s     = 32'd100;
        b_s     = 32'd100;
        @(negedge clk);
        start_s = 1'b0;
        repeat (9) @(negedge clk);
        check("run10.busy", 64'(bus1.busy), 64'd1);
        #2 reset_s = 1'b0;
        #1;
        check("abort.busy", 64'(bus1.busy), 64'd0);
        check("abort.done", 64'(bus1.done), 64'd0);
        check("abort.lo",   64'(bus1.result_lo), 64'd0);
        check("abort.hi",   64'(bus1.result_hi), 64'd0);
        check("abort.nz",   64'(bus1.nz), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_s = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'd3, 32'd5, 0, k1, k4, bz, lk);
        check("post_rst.lat", 64'(k1), 64'd34);
        check("post_rst.lo",  64'(lo_o[0]), 64'd15);

        for (int t = 0; t < 24; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case ($urandom_range(0, 5))
                0:       rop = 2'b00;
                1:       rop = 2'b11;
                2, 3:    rop = 2'b01;
                default: rop = 2'b10;
            endcase
            run_op(rop, pick(), pick(), 0, k1, k4, bz, lk);
            check($sformatf("rnd%0d.lat1", t), 64'(k1), 64'd34);
            check($sformatf("rnd%0d.lat4", t), 64'(k4), 64'd10);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000 reached");
        $fatal(1, "watchdog");
    end
endmodule
